// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and the SRAM controller state type
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERR1, ST_ERR2} ctrl_state_t;
endpackage

// File: rtl/ahb_sram_lane_dec.sv
// ahb_sram_lane_dec: maps transfer size and low address bits to byte-lane mask and error flag
module ahb_sram_lane_dec
    import ahb_pkg::*;
(
    input  logic [2:0] i_hsize,
    input  logic [1:0] i_addr,
    output logic [3:0] o_mask,
    output logic       o_err
);
    // Lanes touched by the transfer; illegal sizes touch none
    always_comb begin
        o_mask = (i_hsize == HSIZE_BYTE) ? 4'b0001 << i_addr :
                 (i_hsize == HSIZE_HALF) ? (i_addr[1] ? 4'b1100 : 4'b0011) :
                 (i_hsize == HSIZE_WORD) ? 4'b1111 : 4'b0000;
        o_err  = ((i_hsize == HSIZE_HALF) && i_addr[0]) ||
                 ((i_hsize == HSIZE_WORD) && (i_addr != 2'b00)) ||
                 (i_hsize >= 3'b011);
    end
endmodule

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: zero-wait AHB-Lite slave driving four byte-lane SRAM macros
module ahb_sram_ctrl
    import ahb_pkg::*;
#(
    parameter int AWIDTH = 13,
    parameter int NLANE  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel_i,
    input  logic [31:0]       haddr_i,
    input  logic [1:0]        htrans_i,
    input  logic              hwrite_i,
    input  logic [2:0]        hsize_i,
    input  logic [31:0]       hwdata_i,
    input  logic              hready_i,
    output logic              hreadyout_o,
    output logic              hresp_o,
    output logic [31:0]       hrdata_o,
    output logic [NLANE-1:0]  sram_cen_o,
    output logic [NLANE-1:0]  sram_wen_o,
    output logic [AWIDTH-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);
    ctrl_state_t       r_state;
    ctrl_state_t       w_next;
    logic              r_write;
    logic [NLANE-1:0]  r_mask;
    logic [AWIDTH-1:0] r_addr;
    logic [NLANE-1:0]  w_mask;
    logic              w_err;
    logic              w_accept;
    logic              w_unused;

    assign w_accept     = hsel_i & hready_i & htrans_i[1];
    assign w_unused     = ^{haddr_i[31:AWIDTH+2], htrans_i[0]};
    assign sram_addr_o  = r_addr;
    assign sram_wdata_o = hwdata_i;

    ahb_sram_lane_dec u_lane_dec (
        .i_hsize (hsize_i),
        .i_addr  (haddr_i[1:0]),
        .o_mask  (w_mask),
        .o_err   (w_err)
    );

    // State register; async reset drops any in-flight access so enables release at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Capture good address phases only, so the SRAM address stays put through errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_mask  <= '0;
            r_addr  <= '0;
        end else if (w_accept && r_state != ST_ERR1 && !w_err) begin
            r_write <= hwrite_i;
            r_mask  <= w_mask;
            r_addr  <= haddr_i[AWIDTH+1:2];
        end
    end

    // Next state and data-phase outputs; ERR2 takes new transfers just like IDLE/ACCESS
    always_comb begin
        w_next      = ST_IDLE;
        hreadyout_o = 1'b1;
        hresp_o     = HRESP_OKAY;
        hrdata_o    = '0;
        sram_cen_o  = '1;
        sram_wen_o  = '1;
        if (r_state == ST_ERR1) begin
            w_next      = ST_ERR2;
            hreadyout_o = 1'b0;
            hresp_o     = HRESP_ERROR;
        end else begin
            w_next  = w_accept ? (w_err ? ST_ERR1 : ST_ACCESS) : ST_IDLE;
            hresp_o = (r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
            if (r_state == ST_ACCESS) begin
                sram_cen_o = r_write ? ~r_mask : '0;
                sram_wen_o = r_write ? ~r_mask : '1;
                hrdata_o   = r_write ? '0 : sram_rdata_i;
            end
        end
    end
endmodule
